// File: rtl/jump_ball_engine.sv
// jump_ball_engine: jump-ball game core driving a scanned ROWSxCOLS LED matrix
// (scrolling obstacle field, ball sprite, LFSR spawner, difficulty ramp).
module jump_ball_engine #(
    parameter int ROWS       = 32,
    parameter int COLS       = 16,
    parameter int BALL_ROW   = 2,
    parameter int TICK_INIT  = 50,
    parameter int TICK_MIN   = 10,
    parameter int SPAWN_INIT = 50,
    parameter int SPAWN_MIN  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump,
    input  logic            start,
    output logic [COLS-1:0] column,
    output logic [ROWS-1:0] com,
    output logic [15:0]     score,
    output logic            game_over
);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(COLS - 3);
    localparam int PW = $clog2(TICK_INIT + 1);
    localparam int GW = $clog2(SPAWN_INIT + 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [HW-1:0] H_TOP  = HW'(COLS - 4);
    localparam logic [PW-1:0] P_INIT = PW'(TICK_INIT);
    localparam logic [PW-1:0] P_MIN  = PW'(TICK_MIN);
    localparam logic [PW-1:0] P_MIN2 = PW'(TICK_MIN + 2);
    localparam logic [GW-1:0] G_INIT = GW'(SPAWN_INIT);
    localparam logic [GW-1:0] G_MIN  = GW'(SPAWN_MIN);
    localparam logic [GW-1:0] G_MIN2 = GW'(SPAWN_MIN + 2);

    typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

    state_t          state, state_n;
    logic [COLS-1:0] field   [ROWS];
    logic [COLS-1:0] field_n [ROWS];
    logic [COLS-1:0] shifted [ROWS];
    logic [COLS-1:0] shape, column_n;
    logic [ROWS-1:0] com_n;
    logic [RW-1:0]   r, r_n;
    logic [HW-1:0]   h, h_n, h_t;
    logic            asc, asc_n, asc_t, up, spawn, hit, start_q, start_e;
    logic [PW-1:0]   div, div_n, period, period_n;
    logic [GW-1:0]   gap, gap_n, spawn_cnt, spawn_cnt_n;
    logic [15:0]     score_n, lfsr;

    // Ball sprite mask for field row i at height hh; corners of the 4x4 box are dark.
    function automatic logic [COLS-1:0] sprite(input int i, input logic [HW-1:0] hh);
        return (i == BALL_ROW || i == BALL_ROW + 3) ? COLS'(6) << hh :
               (i == BALL_ROW + 1 || i == BALL_ROW + 2) ? COLS'(15) << hh : '0;
    endfunction

    assign start_e   = start & ~start_q;
    assign r_n       = (r == R_LAST) ? '0 : r + 1'b1;
    assign com_n     = ROWS'(1) << (R_LAST - r_n);
    assign column_n  = field[r_n] | sprite(int'(r_n), h);
    assign game_over = state == DEAD;

    // Candidate post-tick world, used only when a tick actually fires.
    always_comb begin
        up    = jump & (asc | (h == '0)) & (h < H_TOP);
        h_t   = up ? h + 1'b1 : (h != '0) ? h - 1'b1 : h;
        asc_t = up ? (h_t != H_TOP) : (h == '0);
        spawn = spawn_cnt == gap - 1'b1;
        shape = (lfsr[1:0] == 2'd2) ? COLS'(4'hF) : (lfsr[1:0] == 2'd3) ? COLS'(3'h7) : COLS'(2'h3);
        for (int i = 0; i < ROWS - 1; i++) shifted[i] = field[i + 1];
        shifted[ROWS-1] = '0;
        if (spawn) begin
            shifted[ROWS-1] = shape;
            shifted[ROWS-2] = shifted[ROWS-2] | shape;
            if (lfsr[1:0] == 2'd1) shifted[ROWS-3] = shifted[ROWS-3] | shape;
        end
        hit = 1'b0;
        for (int k = 0; k < 4; k++) hit = hit | (|(shifted[BALL_ROW + k] & sprite(BALL_ROW + k, h_t)));
    end

    always_comb begin
        state_n     = state;
        div_n       = div;
        period_n    = period;
        gap_n       = gap;
        spawn_cnt_n = spawn_cnt;
        score_n     = score;
        h_n         = h;
        asc_n       = asc;
        field_n     = field;
        case (state)
            IDLE: if (start_e) begin
                state_n     = PLAY;
                score_n     = '0;
                div_n       = '0;
                spawn_cnt_n = '0;
            end
            PLAY: if (div != period - 1'b1) div_n = div + 1'b1;
            else begin
                div_n       = '0;
                field_n     = shifted;
                h_n         = h_t;
                asc_n       = asc_t;
                spawn_cnt_n = spawn ? '0 : spawn_cnt + 1'b1;
                if (spawn) begin
                    score_n = (&score) ? score : score + 16'd1;
                    // Shrink the spawn gap first; only once it bottoms out speed up the tick.
                    if (gap > G_MIN) gap_n = (gap > G_MIN2) ? gap - GW'(2) : G_MIN;
                    else period_n = (period > P_MIN2) ? period - PW'(2) : P_MIN;
                end
                if (hit) state_n = DEAD;
            end
            DEAD: if (start_e) begin
                state_n  = IDLE;
                period_n = P_INIT;
                gap_n    = G_INIT;
                field_n  = '{default: '0};
                h_n      = '0;
                asc_n    = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            lfsr      <= 16'hACE1;
            r         <= '0;
            com       <= ROWS'(1) << R_LAST;
            column    <= '0;
            score     <= '0;
            h         <= '0;
            asc       <= 1'b1;
            period    <= P_INIT;
            gap       <= G_INIT;
            div       <= '0;
            spawn_cnt <= '0;
            field     <= '{default: '0};
        end else begin
            state     <= state_n;
            start_q   <= start;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            r         <= r_n;
            com       <= com_n;
            column    <= column_n;
            score     <= score_n;
            h         <= h_n;
            asc       <= asc_n;
            period    <= period_n;
            gap       <= gap_n;
            div       <= div_n;
            spawn_cnt <= spawn_cnt_n;
            field     <= field_n;
        end
    end
endmodule

// File: tb/tb_jump_ball_engine.sv
// tb_jump_ball_engine: directed game scenarios checked cycle by cycle against a
// behavioural game model through an expected-output queue.
module tb_jump_ball_engine;
    localparam int R = 32, C = 16, BR = 2, TI = 4, TM = 2, SI = 7, SM = 3;

    typedef struct {
        logic [15:0] col;
        logic [31:0] com;
        logic [15:0] score;
        logic        go;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, jump, start;
    logic [15:0] column, score;
    logic [31:0] com;
    logic        game_over;

    int n_cmp = 0, n_err = 0;
    exp_t sb[$];

    int          m_state, m_r, m_div, m_period, m_gap, m_sc, m_h;
    bit          m_sq, m_asc;
    logic [15:0] m_lfsr, m_score, m_col;
    logic [31:0] m_com;
    logic [15:0] m_field [R];

    jump_ball_engine #(.ROWS(R), .COLS(C), .BALL_ROW(BR), .TICK_INIT(TI), .TICK_MIN(TM),
                       .SPAWN_INIT(SI), .SPAWN_MIN(SM)) dut (
        .clk(clk), .rst(rst), .jump(jump), .start(start),
        .column(column), .com(com), .score(score), .game_over(game_over));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] spr(input int i, input int hh);
        return (i == BR || i == BR + 3) ? 16'h0006 << hh :
               (i == BR + 1 || i == BR + 2) ? 16'h000F << hh : 16'h0000;
    endfunction

    task automatic model_reset();
        m_state = 0; m_sq = 0; m_lfsr = 16'hACE1; m_r = 0; m_col = 0; m_com = 32'h8000_0000;
        m_score = 0; m_h = 0; m_asc = 1; m_period = TI; m_gap = SI; m_div = 0; m_sc = 0;
        for (int i = 0; i < R; i++) m_field[i] = 0;
    endtask

    task automatic model_clk();
        logic [15:0] nf [R];
        logic [15:0] pl, w;
        bit se, a, spawn, hit;
        int nh, rn;
        se = start && !m_sq;
        m_sq = start;
        pl = m_lfsr;
        m_lfsr = {pl[14:0], pl[15] ^ pl[13] ^ pl[12] ^ pl[10]};
        rn = (m_r + 1) % R;
        m_col = m_field[rn] | spr(rn, m_h);
        m_com = 32'h1 << (R - 1 - rn);
        m_r = rn;
        if (m_state == 0) begin
            if (se) begin m_state = 1; m_score = 0; m_div = 0; m_sc = 0; end
        end else if (m_state == 2) begin
            if (se) begin
                m_state = 0; m_period = TI; m_gap = SI; m_h = 0; m_asc = 1;
                for (int i = 0; i < R; i++) m_field[i] = 0;
            end
        end else if (m_div != m_period - 1) m_div++;
        else begin
            m_div = 0;
            for (int i = 0; i < R - 1; i++) nf[i] = m_field[i + 1];
            nf[R-1] = 0;
            a = (m_h == 0) ? 1'b1 : m_asc;
            if (jump && a && m_h < C - 4) begin nh = m_h + 1; a = (nh != C - 4); end
            else if (m_h > 0) begin nh = m_h - 1; a = 0; end
            else nh = m_h;
            spawn = (m_sc == m_gap - 1);
            m_sc = spawn ? 0 : m_sc + 1;
            if (spawn) begin
                case (pl[1:0])
                    2'd2: w = 16'h000F;
                    2'd3: w = 16'h0007;
                    default: w = 16'h0003;
                endcase
                nf[R-1] |= w; nf[R-2] |= w;
                if (pl[1:0] == 2'd1) nf[R-3] |= w;
                if (m_score != 16'hFFFF) m_score++;
                if (m_gap > SM) m_gap = (m_gap - 2 > SM) ? m_gap - 2 : SM;
                else m_period = (m_period - 2 > TM) ? m_period - 2 : TM;
            end
            hit = 0;
            for (int k = 0; k < 4; k++) if ((nf[BR + k] & spr(BR + k, nh)) != 0) hit = 1;
            m_field = nf; m_h = nh; m_asc = a;
            if (hit) m_state = 2;
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        chk("column", column, e.col);
        chk("com", com, e.com);
        chk("score", score, e.score);
        chk("game_over", game_over, e.go);
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        sb.push_back(exp_t'{m_col, m_com, m_score, m_state == 2});
        #1;
        compare_head();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        sb.push_back(exp_t'{m_col, m_com, m_score, 1'b0});
        chk("rst_com", com, 32'h8000_0000);
        chk("rst_column", column, 0);
        chk("rst_score", score, 0);
        chk("rst_game_over", game_over, 0);
        compare_head();
        #1 rst = 1'b1;
    endtask

    // Idle display must be just the ball at height 0 on an empty field.
    task automatic scan_idle();
        for (int i = 0; i < R; i++) begin
            step();
            chk("scan_com", com, 32'h1 << (R - 1 - m_r));
            chk("scan_col", column, (m_r == BR + 1 || m_r == BR + 2) ? 32'h000F :
                                    (m_r == BR || m_r == BR + 3) ? 32'h0006 : 32'h0000);
        end
    endtask

    initial begin
        logic [15:0] held;
        rst = 1'b1; start = 1'b0; jump = 1'b0;
        #2 do_reset();
        scan_idle();

        start = 1'b1; jump = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 1500 && game_over !== 1'b1; n++) begin
            step();
            if (n == 50 || n == 58) start = ~start;
            if (n == 400) jump = 1'b0;
        end
        chk("dead_after_jump_game", game_over, 1);
        held = m_score;
        repeat (64) step();
        chk("dead_frozen", game_over, 1);

        start = 1'b1; step(); start = 1'b0; step();
        chk("restart_idle", game_over, 0);
        chk("score_held", score, held);
        scan_idle();

        jump = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        chk("score_cleared", score, 0);
        for (int n = 0; n < 1500 && game_over !== 1'b1; n++) step();
        chk("dead_after_still_game", game_over, 1);

        start = 1'b1; step(); start = 1'b0; step();
        start = 1'b1; step(); start = 1'b0; jump = 1'b1;
        repeat (90) step();
        do_reset();
        jump = 1'b0;
        repeat (40) step();
        chk("idle_no_ticks_score", score, 0);
        chk("idle_no_ticks_go", game_over, 0);
        scan_idle();
        chk("queue_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
